// File: rtl/wb_stream_master_pkg.sv
// Shared command bytes, status codes and FSM state encoding for the byte-stream Wishbone master.
package wb_stream_master_pkg;

  localparam logic [7:0] CMD_READ   = 8'hA1;
  localparam logic [7:0] CMD_WRITE  = 8'hA2;

  localparam logic [7:0] ST_ACK     = 8'h00;
  localparam logic [7:0] ST_ERR     = 8'h01;
  localparam logic [7:0] ST_RTY     = 8'h02;
  localparam logic [7:0] ST_TIMEOUT = 8'h03;
  localparam logic [7:0] ST_UNKNOWN = 8'hFE;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_BUS   = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

endpackage

// File: rtl/wb_stream_serdes.sv
// N-byte MSB-first shift-in register with parallel load, plus a byte selector (idx 0 = MSB byte).
// Single-cycle: shift/load take effect on the next edge; the selector is combinational.
module wb_stream_serdes #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           shift,
  input  logic [7:0]     shift_byte,
  input  logic           load,
  input  logic [8*N-1:0] load_word,
  output logic [8*N-1:0] word,
  input  logic [7:0]     idx,
  output logic [7:0]     idx_byte
);

  logic [8*N-1:0] shifted;

  always_comb begin
    shifted      = word << 8;
    shifted[7:0] = shift_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
    end else if (load) begin
      word <= load_word;
    end else if (shift) begin
      word <= shifted;
    end
  end

  // Out-of-range indices read as zero rather than wrapping.
  always_comb begin
    idx_byte = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == 8'(N - 1 - i)) idx_byte = word[8*i +: 8];
    end
  end

endmodule

// File: rtl/wb_stream_master.sv
// Framed byte-stream commands to single classic Wishbone cycles; status (+read data) returned on tx.
// Read latency: last address byte to status valid = 2 cycles at zero wait; rx stalls while busy, tx holds until tready.
module wb_stream_master
  import wb_stream_master_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_tdata,
  input  logic                    rx_tvalid,
  output logic                    rx_tready,
  output logic [7:0]              tx_tdata,
  output logic                    tx_tvalid,
  input  logic                    tx_tready,
  output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  output logic                    wbm_we_o,
  output logic [SELECT_WIDTH-1:0] wbm_sel_o,
  output logic                    wbm_stb_o,
  output logic                    wbm_cyc_o,
  input  logic                    wbm_ack_i,
  input  logic                    wbm_err_i,
  input  logic                    wbm_rty_i,
  output logic                    busy
);

  localparam int          AB       = ADDR_WIDTH / 8;
  localparam int          DB       = DATA_WIDTH / 8;
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT) - 32'd1;

  logic [2:0]            state, next_state;
  logic [7:0]            byte_cnt;
  logic [31:0]           tmo_cnt;
  logic                  is_write;
  logic [7:0]            status;
  logic                  rx_fire, tx_fire, term, timed_out, bus_done, resp_last, valid_cmd;
  logic [7:0]            sel_idx, data_byte, adr_byte_unused;
  logic [DATA_WIDTH-1:0] rdata_word;
  logic                  rx_ready_d, bus_d, busy_d, tx_valid_d;
  logic [7:0]            tx_data_d;

  assign rx_fire    = rx_tvalid & rx_tready;
  assign tx_fire    = tx_tvalid & tx_tready;
  assign term       = wbm_ack_i | wbm_err_i | wbm_rty_i;
  assign timed_out  = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
  assign bus_done   = (state == S_BUS) && (term || timed_out);
  assign valid_cmd  = (rx_tdata == CMD_READ) || (rx_tdata == CMD_WRITE);
  assign resp_last  = (is_write || status == ST_UNKNOWN) ? (byte_cnt == 8'd0) : (byte_cnt == 8'(DB));
  assign sel_idx    = tx_fire ? byte_cnt + 8'd1 : byte_cnt;
  assign rdata_word = wbm_ack_i ? wbm_dat_i : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (rx_fire) next_state = valid_cmd ? S_ADDR : S_RESP;
      S_ADDR:  if (rx_fire && byte_cnt == 8'(AB - 1)) next_state = is_write ? S_WDATA : S_BUS;
      S_WDATA: if (rx_fire && byte_cnt == 8'(DB - 1)) next_state = S_BUS;
      S_BUS:   if (term || timed_out) next_state = S_RESP;
      S_RESP:  if (tx_fire && resp_last) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs are computed from next_state so every port comes straight from a flop.
  always_comb begin
    rx_ready_d = (next_state == S_IDLE) || (next_state == S_ADDR) || (next_state == S_WDATA);
    bus_d      = (next_state == S_BUS);
    busy_d     = (next_state != S_IDLE);
    tx_valid_d = (state == S_RESP) && !(tx_fire && resp_last);
    tx_data_d  = tx_tdata;
    if (state == S_RESP && (!tx_tvalid || tx_fire)) begin
      tx_data_d = (sel_idx == 8'd0) ? status : data_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_tready <= 1'b0;
      tx_tvalid <= 1'b0;
      tx_tdata  <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      busy      <= 1'b0;
    end else begin
      rx_tready <= rx_ready_d;
      tx_tvalid <= tx_valid_d;
      tx_tdata  <= tx_data_d;
      wbm_cyc_o <= bus_d;
      wbm_stb_o <= bus_d;
      wbm_we_o  <= bus_d & is_write;
      wbm_sel_o <= bus_d ? '1 : '0;
      busy      <= busy_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      tmo_cnt  <= '0;
      is_write <= 1'b0;
      status   <= '0;
    end else begin
      if (next_state != state)    byte_cnt <= '0;
      else if (rx_fire || tx_fire) byte_cnt <= byte_cnt + 8'd1;
      tmo_cnt <= (state == S_BUS) ? tmo_cnt + 32'd1 : 32'd0;
      if (state == S_IDLE && rx_fire) begin
        is_write <= (rx_tdata == CMD_WRITE);
        if (!valid_cmd) status <= ST_UNKNOWN;
      end
      // ack > err > rty; timeout only when nothing terminated.
      if (bus_done) begin
        if (wbm_ack_i)      status <= ST_ACK;
        else if (wbm_err_i) status <= ST_ERR;
        else if (wbm_rty_i) status <= ST_RTY;
        else                status <= ST_TIMEOUT;
      end
    end
  end

  wb_stream_serdes #(.N(AB)) u_addr (
    .clk        (clk),
    .rst        (rst),
    .shift      ((state == S_ADDR) && rx_fire),
    .shift_byte (rx_tdata),
    .load       (1'b0),
    .load_word  ({ADDR_WIDTH{1'b0}}),
    .word       (wbm_adr_o),
    .idx        (8'd0),
    .idx_byte   (adr_byte_unused)
  );

  // Write data register doubles as the read-data capture for the response.
  wb_stream_serdes #(.N(DB)) u_data (
    .clk        (clk),
    .rst        (rst),
    .shift      ((state == S_WDATA) && rx_fire),
    .shift_byte (rx_tdata),
    .load       (bus_done && !is_write),
    .load_word  (rdata_word),
    .word       (wbm_dat_o),
    .idx        (sel_idx - 8'd1),
    .idx_byte   (data_byte)
  );

endmodule

// File: tb/tb_wb_stream_master.sv
// Directed bench for wb_stream_master: frame parsing, bus termination, timeout, backpressure and reset.
module tb_wb_stream_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_tdata;
  logic        rx_tvalid;
  logic        rx_tready;
  logic [7:0]  tx_tdata;
  logic        tx_tvalid;
  logic        tx_tready;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_stb_o, wbm_cyc_o;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;
  logic        wbm_rty_i = 1'b0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_stream_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SELECT_WIDTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i), .busy(busy)
  );

  // Slave: raises {ack,err,rty}=slv_term combinationally after slv_wait cycles of cyc.
  logic [2:0]  slv_term = 3'b100;
  int          slv_wait = 0;
  logic [31:0] slv_rdata = 32'h0;
  int          cyc_cycles = 0, stb_cycles = 0;
  logic [31:0] cap_adr, cap_dat;
  logic        cap_we;
  logic [3:0]  cap_sel;
  assign wbm_dat_i = slv_rdata;

  always @(negedge clk) begin
    {wbm_ack_i, wbm_err_i, wbm_rty_i} = 3'b000;
    if (wbm_cyc_o) begin
      cap_adr = wbm_adr_o; cap_dat = wbm_dat_o; cap_we = wbm_we_o; cap_sel = wbm_sel_o;
      if (cyc_cycles == slv_wait) {wbm_ack_i, wbm_err_i, wbm_rty_i} = slv_term;
      cyc_cycles++;
      if (wbm_stb_o) stb_cycles++;
    end
  end

  // Response collector with a stall-stability monitor.
  logic [7:0] tx_seen[$];
  int         stall_err = 0;
  logic       was_stall = 1'b0;
  logic [7:0] stall_byte = 8'h00;

  always @(negedge clk) begin
    if (was_stall && (!tx_tvalid || tx_tdata !== stall_byte)) stall_err++;
    was_stall  = tx_tvalid && !tx_tready;
    stall_byte = tx_tdata;
    if (tx_tvalid && tx_tready) tx_seen.push_back(tx_tdata);
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_tdata = b; rx_tvalid = 1'b1;
    while (!rx_tready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!rx_tready) begin failures++; $display("FAIL send_byte rx_tready stuck low byte=%h", b); end
    @(posedge clk); #1;
    rx_tvalid = 1'b0;
  endtask

  task automatic send_bytes(input logic [71:0] v, input int n);
    for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8]);
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    ok = !busy;
  endtask

  task automatic start_test(input logic [2:0] term, input int wt, input logic [31:0] rd);
    slv_term = term; slv_wait = wt; slv_rdata = rd;
    cyc_cycles = 0; stb_cycles = 0; stall_err = 0;
    tx_seen.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_tvalid = 1'b0; rx_tdata = 8'h00; tx_tready = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({rx_tready, tx_tvalid, tx_tdata, busy} !== 11'd0) begin
      failures++; $display("FAIL reset_stream got=%b exp=0", {rx_tready, tx_tvalid, tx_tdata, busy});
    end
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !== 71'd0) begin
      failures++; $display("FAIL reset_wb got=%h exp=0", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o});
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (rx_tready !== 1'b0) begin failures++; $display("FAIL reset_rdy_before_edge got=%b exp=0", rx_tready); end
    @(posedge clk); #1;
    checks++;
    if (rx_tready !== 1'b1) begin failures++; $display("FAIL reset_rdy_after_edge got=%b exp=1", rx_tready); end
  endtask

  task automatic test_read_ack;
    bit ok;
    logic [7:0] exp[5] = '{8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    start_test(3'b100, 0, 32'hDEADBEEF);
    send_bytes(72'hA1_0000_1004, 5);
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, tx_tvalid} !== 3'b110) begin
      failures++; $display("FAIL read_cyc_rise got=%b exp=110", {wbm_cyc_o, wbm_stb_o, tx_tvalid});
    end
    @(posedge clk); #1;
    checks++;
    if ({wbm_cyc_o, tx_tvalid} !== 2'b00) begin failures++; $display("FAIL read_cyc_fall got=%b exp=00", {wbm_cyc_o, tx_tvalid}); end
    @(posedge clk); #1;
    checks++;
    if ({tx_tvalid, tx_tdata} !== 9'h100) begin failures++; $display("FAIL read_latency got=%h exp=100", {tx_tvalid, tx_tdata}); end
    wait_idle(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL read_idle busy stuck got=%b exp=0", busy); end
    checks++;
    if ({cap_adr, cap_we, cap_sel} !== {32'h00001004, 1'b0, 4'hF}) begin
      failures++; $display("FAIL read_bus adr=%h we=%b sel=%h exp=00001004 0 f", cap_adr, cap_we, cap_sel);
    end
    checks++;
    if (cyc_cycles != 1) begin failures++; $display("FAIL read_cyc_len got=%0d exp=1", cyc_cycles); end
    checks++;
    if (tx_seen.size() != 5) begin failures++; $display("FAIL read_tx_count got=%0d exp=5", tx_seen.size()); end
    else foreach (exp[i]) begin
      checks++;
      if (tx_seen[i] !== exp[i]) begin failures++; $display("FAIL read_tx[%0d] got=%h exp=%h", i, tx_seen[i], exp[i]); end
    end
  endtask

  task automatic test_write_wait;
    bit ok;
    start_test(3'b100, 3, 32'hFFFFFFFF);
    send_bytes(72'hA2_0000_2000_1234_5678, 9);
    wait_idle(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL write_idle busy stuck got=%b exp=0", busy); end
    checks++;
    if ({cap_adr, cap_dat, cap_we, cap_sel} !== {32'h00002000, 32'h12345678, 1'b1, 4'hF}) begin
      failures++; $display("FAIL write_bus adr=%h dat=%h we=%b sel=%h exp=00002000 12345678 1 f", cap_adr, cap_dat, cap_we, cap_sel);
    end
    checks++;
    if (cyc_cycles != 4 || stb_cycles != 4) begin
      failures++; $display("FAIL write_cyc_len got=%0d/%0d exp=4/4", cyc_cycles, stb_cycles);
    end
    checks++;
    if (tx_seen.size() != 1 || tx_seen[0] !== 8'h00) begin
      failures++; $display("FAIL write_tx got=%0d bytes first=%h exp=1 byte 00", tx_seen.size(), tx_seen.size() > 0 ? tx_seen[0] : 8'hxx);
    end
  endtask

  task automatic test_termination;
    bit ok;
    logic [2:0]  term[4] = '{3'b010, 3'b001, 3'b101, 3'b011};
    logic [7:0]  st[4]   = '{8'h01, 8'h02, 8'h00, 8'h01};
    logic [31:0] dw[4]   = '{32'h0, 32'h0, 32'hCAFEF00D, 32'h0};
    for (int t = 0; t < 4; t++) begin
      start_test(term[t], 0, 32'hCAFEF00D);
      send_bytes(72'hA1_0000_0040, 5);
      wait_idle(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL term%0d_idle busy stuck got=%b exp=0", t, busy); end
      checks++;
      if (tx_seen.size() != 5) begin failures++; $display("FAIL term%0d_tx_count got=%0d exp=5", t, tx_seen.size()); end
      else begin
        checks++;
        if ({tx_seen[0], tx_seen[1], tx_seen[2], tx_seen[3], tx_seen[4]} !== {st[t], dw[t]}) begin
          failures++; $display("FAIL term%0d_tx got=%h%h%h%h%h exp=%h%h", t,
                               tx_seen[0], tx_seen[1], tx_seen[2], tx_seen[3], tx_seen[4], st[t], dw[t]);
        end
      end
    end
  endtask

  task automatic test_timeout;
    bit ok;
    start_test(3'b000, 0, 32'h89ABCDEF);
    send_bytes(72'hA1_0000_0080, 5);
    wait_idle(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL timeout_idle busy stuck got=%b exp=0", busy); end
    checks++;
    if (cyc_cycles != 8 || stb_cycles != 8) begin
      failures++; $display("FAIL timeout_len got=%0d/%0d exp=8/8", cyc_cycles, stb_cycles);
    end
    checks++;
    if (tx_seen.size() != 5) begin failures++; $display("FAIL timeout_tx_count got=%0d exp=5", tx_seen.size()); end
    else begin
      checks++;
      if ({tx_seen[0], tx_seen[1], tx_seen[2], tx_seen[3], tx_seen[4]} !== 40'h03_0000_0000) begin
        failures++; $display("FAIL timeout_tx got=%h%h%h%h%h exp=0300000000", tx_seen[0], tx_seen[1], tx_seen[2], tx_seen[3], tx_seen[4]);
      end
    end
  endtask

  task automatic test_bad_cmd;
    bit ok;
    start_test(3'b100, 0, 32'h0);
    send_byte(8'h55);
    checks++;
    if ({busy, rx_tready} !== 2'b10) begin failures++; $display("FAIL bad_busy got=%b exp=10", {busy, rx_tready}); end
    wait_idle(ok);
    @(posedge clk); #1;
    checks++;
    if (!ok || busy !== 1'b0 || rx_tready !== 1'b1) begin
      failures++; $display("FAIL bad_idle busy=%b rdy=%b exp=0 1", busy, rx_tready);
    end
    checks++;
    if (tx_seen.size() != 1 || tx_seen[0] !== 8'hFE || cyc_cycles != 0) begin
      failures++; $display("FAIL bad_tx got=%0d bytes first=%h cyc=%0d exp=1 byte fe cyc=0",
                           tx_seen.size(), tx_seen.size() > 0 ? tx_seen[0] : 8'hxx, cyc_cycles);
    end
  endtask

  task automatic test_backpressure;
    int n = 0;
    logic [7:0] exp[5] = '{8'h00, 8'h01, 8'h23, 8'hA5, 8'hC3};
    start_test(3'b100, 1, 32'h0123A5C3);
    tx_tready = 1'b0;
    send_bytes(72'hA1_0000_00C0, 5);
    while (busy && n < 60) begin @(posedge clk); #1; tx_tready = ~tx_tready; n++; end
    tx_tready = 1'b1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL bp_idle busy stuck got=%b exp=0", busy); end
    checks++;
    if (stall_err != 0) begin failures++; $display("FAIL bp_stable got=%0d unstable cycles exp=0", stall_err); end
    checks++;
    if (tx_seen.size() != 5) begin failures++; $display("FAIL bp_tx_count got=%0d exp=5", tx_seen.size()); end
    else foreach (exp[i]) begin
      checks++;
      if (tx_seen[i] !== exp[i]) begin failures++; $display("FAIL bp_tx[%0d] got=%h exp=%h", i, tx_seen[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    start_test(3'b000, 0, 32'h0);
    send_bytes(72'hA1_0000_0100, 5);
    @(posedge clk); #3;
    rst = 1'b1; #1;
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, busy, tx_tvalid} !== 4'b0000) begin
      failures++; $display("FAIL rst_mid_async got=%b exp=0000", {wbm_cyc_o, wbm_stb_o, busy, tx_tvalid});
    end
    @(negedge clk); rst = 1'b0;
    repeat (12) @(posedge clk); #1;
    checks++;
    if (tx_seen.size() != 0 || busy !== 1'b0) begin
      failures++; $display("FAIL rst_mid_quiet got=%0d bytes busy=%b exp=0 bytes busy=0", tx_seen.size(), busy);
    end
    start_test(3'b100, 0, 32'h5A5A0001);
    send_bytes(72'hA1_0000_0008, 5);
    wait_idle(ok);
    checks++;
    if (!ok || cap_adr !== 32'h00000008) begin failures++; $display("FAIL rst_next_adr got=%h exp=00000008", cap_adr); end
    checks++;
    if (tx_seen.size() != 5) begin failures++; $display("FAIL rst_next_count got=%0d exp=5", tx_seen.size()); end
    else begin
      checks++;
      if ({tx_seen[0], tx_seen[1], tx_seen[2], tx_seen[3], tx_seen[4]} !== 40'h00_5A5A_0001) begin
        failures++; $display("FAIL rst_next_tx got=%h%h%h%h%h exp=005a5a0001", tx_seen[0], tx_seen[1], tx_seen[2], tx_seen[3], tx_seen[4]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_read_ack;
    test_write_wait;
    test_termination;
    test_timeout;
    test_bad_cmd;
    test_backpressure;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
